// File: rtl/muldiv_pkg.sv
// Shared EX-stage definitions: ALU control codes, multiply/divide op codes,
// the muldiv FSM state enum and the default datapath width.
package muldiv_pkg;

    localparam int WORD_SIZE_DEFAULT = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_NOR = 3'd5
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit with HI/LO result registers.
// Works on operand magnitudes and applies sign correction in a final cycle.
//
// state | meaning
// IDLE  | waiting for start; hi/lo hold the last result
// CALC  | one shift-add / shift-subtract step per cycle, count 0..WORD_SIZE-1
// FIX   | sign correction, hi/lo write, done pulse, back to IDLE
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] hi,
    output logic [WORD_SIZE-1:0] lo
);

    localparam int CW = $clog2(WORD_SIZE);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WORD_SIZE - 1);

    muldiv_state_e          state_q, state_d;
    muldiv_op_e             op_q, op_d;
    logic [CW-1:0]          count_q, count_d;
    logic [WORD_SIZE-1:0]   a_mag_q, a_mag_d;
    logic [WORD_SIZE-1:0]   b_mag_q, b_mag_d;
    logic [2*WORD_SIZE-1:0] acc_q, acc_d;
    logic                   neg_res_q, neg_res_d;
    logic                   neg_rem_q, neg_rem_d;
    logic [WORD_SIZE-1:0]   hi_q, hi_d;
    logic [WORD_SIZE-1:0]   lo_q, lo_d;
    logic                   done_q, done_d;

    function automatic logic [2*WORD_SIZE-1:0] neg_dword(input logic                   neg,
                                                        input logic [2*WORD_SIZE-1:0] v);
        return neg ? (~v + (2*WORD_SIZE)'(1)) : v;
    endfunction

    function automatic logic [WORD_SIZE-1:0] neg_word(input logic                 neg,
                                                     input logic [WORD_SIZE-1:0] v);
        return neg ? (~v + WORD_SIZE'(1)) : v;
    endfunction

    muldiv_op_e           op_in;
    logic                 in_signed;
    logic                 in_div;
    logic                 sign_a;
    logic                 sign_b;
    logic [WORD_SIZE-1:0] a_abs;
    logic [WORD_SIZE-1:0] b_abs;

    assign op_in     = muldiv_op_e'(op);
    assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign in_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
    assign sign_a    = in_signed & a[WORD_SIZE-1];
    assign sign_b    = in_signed & b[WORD_SIZE-1];
    // 0x80000000 negates to itself, which is its correct unsigned magnitude
    assign a_abs     = neg_word(sign_a, a);
    assign b_abs     = neg_word(sign_b, b);

    logic [WORD_SIZE:0]     mul_sum;
    logic [2*WORD_SIZE-1:0] acc_mul;
    logic [WORD_SIZE:0]     div_trial;
    logic                   div_fits;
    logic [WORD_SIZE-1:0]   div_rem;
    logic [2*WORD_SIZE-1:0] acc_div;

    assign mul_sum   = {1'b0, acc_q[2*WORD_SIZE-1:WORD_SIZE]}
                     + (acc_q[0] ? {1'b0, a_mag_q} : {(WORD_SIZE+1){1'b0}});
    assign acc_mul   = {mul_sum, acc_q[WORD_SIZE-1:1]};

    // Partial remainder shifted left with the next dividend bit; it can reach WORD_SIZE+1 bits.
    assign div_trial = acc_q[2*WORD_SIZE-1:WORD_SIZE-1];
    assign div_fits  = div_trial >= {1'b0, b_mag_q};
    assign div_rem   = div_fits ? (div_trial[WORD_SIZE-1:0] - b_mag_q) : div_trial[WORD_SIZE-1:0];
    assign acc_div   = {div_rem, acc_q[WORD_SIZE-2:0], div_fits};

    logic                   is_div_q;
    logic [2*WORD_SIZE-1:0] prod_fixed;
    logic [WORD_SIZE-1:0]   quo_fixed;
    logic [WORD_SIZE-1:0]   rem_fixed;

    assign is_div_q   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign prod_fixed = neg_dword(neg_res_q, acc_q);
    assign quo_fixed  = neg_word(neg_res_q, acc_q[WORD_SIZE-1:0]);
    assign rem_fixed  = neg_word(neg_rem_q, acc_q[2*WORD_SIZE-1:WORD_SIZE]);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        count_d   = count_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = op_in;
                    a_mag_d   = a_abs;
                    b_mag_d   = b_abs;
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    acc_d     = {{WORD_SIZE{1'b0}}, (in_div ? a_abs : b_abs)};
                    count_d   = '0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                acc_d   = is_div_q ? acc_div : acc_mul;
                count_d = count_q + CW'(1);
                if (count_q == LAST_COUNT) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fixed[2*WORD_SIZE-1:WORD_SIZE];
                    lo_d = prod_fixed[WORD_SIZE-1:0];
                end else begin
                    // Divide by zero: remainder path already yields the dividend
                    hi_d = rem_fixed;
                    lo_d = (b_mag_q == '0) ? {WORD_SIZE{1'b1}} : quo_fixed;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_MULT;
            count_q   <= '0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            count_q   <= count_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus per-cycle compare,
// directed cases with literal results and randomized operations.
module tb_muldiv_unit;

    localparam logic [1:0] T_MULT  = 2'b00;
    localparam logic [1:0] T_MULTU = 2'b01;
    localparam logic [1:0] T_DIV   = 2'b10;
    localparam logic [1:0] T_DIVU  = 2'b11;
    localparam int LAT = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WORD_SIZE(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Arithmetic definition of every op; returns {hi, lo}.
    function automatic logic [63:0] ref_calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        logic [31:0] q;
        logic [31:0] r;
        p = '0;
        case (o)
            T_MULT:  p = 64'(longint'($signed(x)) * longint'($signed(y)));
            T_MULTU: p = {32'h0, x} * {32'h0, y};
            default: begin
                if (y == 32'h0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else if (o == T_DIV && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    p = {32'h0, 32'h8000_0000};
                end else if (o == T_DIV) begin
                    q = $signed(x) / $signed(y);
                    r = $signed(x) % $signed(y);
                    p = {r, q};
                end else begin
                    q = x / y;
                    r = x % y;
                    p = {r, q};
                end
            end
        endcase
        return p;
    endfunction

    // Transaction-level model: a result appears LAT edges after an accepted start.
    int          remaining = 0;
    logic [63:0] pend = '0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_done = 1'b0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            remaining <= 0;
            m_hi      <= '0;
            m_lo      <= '0;
            m_done    <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (remaining > 0) begin
                remaining <= remaining - 1;
                if (remaining == 1) begin
                    m_hi   <= pend[63:32];
                    m_lo   <= pend[31:0];
                    m_done <= 1'b1;
                end
            end else if (start) begin
                pend      <= ref_calc(op, a, b);
                remaining <= LAT;
            end
        end
    end

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check32("busy", {31'h0, busy}, {31'h0, (remaining != 0)});
            check32("done", {31'h0, done}, {31'h0, m_done});
            check32("hi", hi, m_hi);
            check32("lo", lo, m_lo);
        end
    end

    // Starts an op at the current negedge and waits (bounded) for done.
    // intr >= 0 pulses a DIVU 100/7 start while busy at that cycle offset.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int intr, output int lat, output int bcnt);
        int k;
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        bcnt = 0;
        while (done !== 1'b1 && k < LAT + 8) begin
            if (busy === 1'b1) bcnt++;
            if (k == intr) begin
                op = T_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        lat = k;
    endtask

    task automatic directed(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] wh, input logic [31:0] wl);
        int lat;
        int bcnt;
        run_op(o, x, y, -1, lat, bcnt);
        check_int({nm, " latency"}, lat, LAT);
        check_int({nm, " busy cycles"}, bcnt, LAT);
        check32({nm, " hi"}, hi, wh);
        check32({nm, " lo"}, lo, wl);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        int bcnt;
        int seen;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check32("reset busy", {31'h0, busy}, 32'h0);
        check32("reset done", {31'h0, done}, 32'h0);
        check32("reset hi", hi, 32'h0);
        check32("reset lo", lo, 32'h0);

        directed("multu max", T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        directed("mult -7*3", T_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        directed("multu 69*69", T_MULTU, 32'd69, 32'd69, 32'h0, 32'd4761);
        directed("div -7/2", T_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        directed("divu 7/2", T_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        directed("div 7/-2", T_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        directed("div by zero", T_DIV, 32'd69, 32'd0, 32'd69, 32'hFFFF_FFFF);
        directed("div overflow", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        run_op(T_MULTU, 32'd5, 32'd6, 10, lat, bcnt);
        check_int("start while busy latency", lat, LAT);
        check32("start while busy hi", hi, 32'h0);
        check32("start while busy lo", lo, 32'd30);
        repeat (3) @(negedge clk);
        check32("ignored start busy", {31'h0, busy}, 32'h0);

        directed("pre-reset div", T_DIV, 32'd1234, 32'd5, 32'd4, 32'd246);
        op = T_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check32("abort busy", {31'h0, busy}, 32'h0);
        check32("abort done", {31'h0, done}, 32'h0);
        check32("abort hi", hi, 32'h0);
        check32("abort lo", lo, 32'h0);
        seen = 0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check_int("abort no done", seen, 0);

        directed("b2b first", T_MULTU, 32'd3, 32'd4, 32'h0, 32'd12);
        directed("b2b second", T_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        for (int i = 0; i < 250; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            int          intr;
            ro = 2'($urandom_range(0, 3));
            ra = pick_operand();
            rb = pick_operand();
            intr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
            run_op(ro, ra, rb, intr, lat, bcnt);
            check_int("random latency", lat, LAT);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
